// File: rtl/isa_pkg.sv
// isa_pkg: opcode/aluop encodings, instruction field positions and the decoded bundle shared by decode and trace checking.
package isa_pkg;
  localparam int RSTATUS_REG_DEF = 30;
  localparam int IMM_W_DEF = 17;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_LSB = 17;
  localparam int RT_LSB = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALU_LSB = 2;
  localparam logic [31:0] EXC_NONE = 32'd0;
  localparam logic [31:0] EXC_ADD = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB = 32'd3;
  typedef struct packed {
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] imm;
    logic        is_rtype;
    logic        use_imm;
    logic        reg_we;
    logic        illegal;
    logic [31:0] exc_code;
    logic [4:0]  exc_reg;
  } bundle_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/insn_decode_stage_if.sv
// insn_decode_stage_if: fetch-side valid/ready word input and execute-side decoded bundle output.
interface insn_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_shamt;
  logic [4:0]  out_aluop;
  logic [31:0] out_imm;
  logic        out_is_rtype;
  logic        out_use_imm;
  logic        out_reg_we;
  logic        out_illegal;
  logic [31:0] out_exc_code;
  logic [4:0]  out_exc_reg;
  modport master (
    output in_valid, in_insn, out_ready,
    input  in_ready, out_valid, out_insn, out_rd, out_rs, out_rt, out_shamt, out_aluop,
           out_imm, out_is_rtype, out_use_imm, out_reg_we, out_illegal, out_exc_code, out_exc_reg
  );
  modport slave (
    input  in_valid, in_insn, out_ready,
    output in_ready, out_valid, out_insn, out_rd, out_rs, out_rt, out_shamt, out_aluop,
           out_imm, out_is_rtype, out_use_imm, out_reg_we, out_illegal, out_exc_code, out_exc_reg
  );
endinterface

// File: rtl/insn_decoder.sv
// insn_decoder: purely combinational split of a 32-bit instruction word into the decoded bundle.
module insn_decoder
  import isa_pkg::*;
#(
  parameter int RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int IMM_W = IMM_W_DEF
) (
  input  logic [31:0] insn,
  output bundle_t     dec
);
  logic [4:0] opc;
  logic [4:0] alu;
  logic       rtype;
  logic       addi;
  logic       legal;
  always_comb begin
    opc = insn[OPC_LSB +: 5];
    alu = insn[ALU_LSB +: 5];
    rtype = opc == OP_RTYPE;
    addi = opc == OP_ADDI;
    legal = addi || (rtype && alu inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA});
    dec.insn = insn;
    dec.rd = insn[RD_LSB +: 5];
    dec.rs = insn[RS_LSB +: 5];
    dec.rt = insn[RT_LSB +: 5];
    dec.shamt = insn[SHAMT_LSB +: 5];
    dec.aluop = addi ? ALU_ADD : alu;
    dec.imm = {{(32 - IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
    dec.is_rtype = rtype;
    dec.use_imm = addi;
    dec.illegal = !legal;
    dec.reg_we = legal && dec.rd != 5'd0;
    // exc code is produced even when rd=0, since overflow still traps
    dec.exc_code = addi ? EXC_ADDI : !rtype ? EXC_NONE : alu == ALU_ADD ? EXC_ADD : alu == ALU_SUB ? EXC_SUB : EXC_NONE;
    dec.exc_reg = 5'(RSTATUS_REG);
  end
endmodule

// File: rtl/insn_decode_stage.sv
// insn_decode_stage: registered decode stage with a 2-entry skid buffer between fetch and execute.
module insn_decode_stage
  import isa_pkg::*;
#(
  parameter int RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int IMM_W = IMM_W_DEF
) (
  input logic clock,
  input logic reset,
  input logic flush,
  insn_decode_stage_if.slave bus
);
  bundle_t     dec;
  bundle_t     head_q, head_d;
  bundle_t     tail_q, tail_d;
  skid_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        accept;
  logic        pop;
  insn_decoder #(.RSTATUS_REG(RSTATUS_REG), .IMM_W(IMM_W)) u_dec (.insn(bus.in_insn), .dec(dec));
  always_comb begin
    accept = bus.in_valid && in_ready_q;
    pop = state_q != EMPTY && bus.out_ready;
    state_d = flush ? EMPTY
            : state_q == EMPTY ? (accept ? ONE : EMPTY)
            : state_q == ONE ? (accept && !pop ? TWO : !accept && pop ? EMPTY : ONE)
            : (pop ? ONE : TWO);
    head_d = state_q == TWO && pop ? tail_q
           : accept && (state_q == EMPTY || pop) ? dec : head_q;
    tail_d = accept && state_q == ONE && !pop ? dec : tail_q;
    // ready is registered so fetch never sees a combinational path from out_ready
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_insn = head_q.insn;
  assign bus.out_rd = head_q.rd;
  assign bus.out_rs = head_q.rs;
  assign bus.out_rt = head_q.rt;
  assign bus.out_shamt = head_q.shamt;
  assign bus.out_aluop = head_q.aluop;
  assign bus.out_imm = head_q.imm;
  assign bus.out_is_rtype = head_q.is_rtype;
  assign bus.out_use_imm = head_q.use_imm;
  assign bus.out_reg_we = head_q.reg_we;
  assign bus.out_illegal = head_q.illegal;
  assign bus.out_exc_code = head_q.exc_code;
  assign bus.out_exc_reg = head_q.exc_reg;
endmodule

// File: tb/tb_insn_decode_stage.sv
// tb_insn_decode_stage: directed vector table, skid corner sequences and randomized traffic against a queue model.
module tb_insn_decode_stage;
  import isa_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clock = ~clock;
  insn_decode_stage_if bus();
  insn_decode_stage #(.RSTATUS_REG(30), .IMM_W(17)) dut (.clock(clock), .reset(reset), .flush(flush), .bus(bus));
  int checks = 0;
  int errors = 0;
  bundle_t act;
  always_comb act = '{insn: bus.out_insn, rd: bus.out_rd, rs: bus.out_rs, rt: bus.out_rt, shamt: bus.out_shamt,
                      aluop: bus.out_aluop, imm: bus.out_imm, is_rtype: bus.out_is_rtype, use_imm: bus.out_use_imm,
                      reg_we: bus.out_reg_we, illegal: bus.out_illegal, exc_code: bus.out_exc_code, exc_reg: bus.out_exc_reg};
  typedef struct {
    logic [31:0] w;
    logic [4:0]  rd, rs, rt, sh, alu;
    logic [31:0] imm;
    logic        rty, ui, we, ill;
    logic [31:0] exc;
  } vec_t;
  vec_t tbl[9];
  logic [31:0] q[$];
  task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic bundle_t model(input logic [31:0] w);
    bundle_t b;
    int unsigned opc, alu;
    bit rt, ad, legal;
    opc = w >> 27;
    alu = (w >> 2) & 31;
    rt = opc == 0;
    ad = opc == 5;
    legal = ad || (rt && alu <= 5);
    b.insn = w;
    b.rd = 5'((w >> 22) & 31);
    b.rs = 5'((w >> 17) & 31);
    b.rt = 5'((w >> 12) & 31);
    b.shamt = 5'((w >> 7) & 31);
    b.aluop = ad ? 5'd0 : 5'(alu);
    b.imm = w[16] ? ((w & 32'h1FFFF) | 32'hFFFE0000) : (w & 32'h1FFFF);
    b.is_rtype = rt;
    b.use_imm = ad;
    b.illegal = !legal;
    b.reg_we = legal && b.rd != 5'd0;
    b.exc_code = ad ? 32'd2 : (rt && alu == 0) ? 32'd1 : (rt && alu == 1) ? 32'd3 : 32'd0;
    b.exc_reg = 5'd30;
    return b;
  endfunction
  initial begin
    bundle_t e;
    logic [31:0] w;
    bit rdy_m, acc, pp;
    tbl[0] = '{32'h28400005, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h5, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[1] = '{32'h00C22000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[2] = '{32'h01022004, 5'd4, 5'd1, 5'd2, 5'd0, 5'd1, 32'h2004, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3};
    tbl[3] = '{32'h02020110, 5'd8, 5'd1, 5'd0, 5'd2, 5'd4, 32'h110, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[4] = '{32'h2DC10000, 5'd23, 5'd0, 5'd16, 5'd0, 5'd0, 32'hFFFF0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[5] = '{32'hF8400000, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[6] = '{32'h00400020, 5'd1, 5'd0, 5'd0, 5'd0, 5'd8, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    tbl[7] = '{32'h00022008, 5'd0, 5'd1, 5'd2, 5'd0, 5'd2, 32'h2008, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[8] = '{32'h00022000, 5'd0, 5'd1, 5'd2, 5'd0, 5'd0, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
    bus.in_valid = 1'b0;
    bus.in_insn = '0;
    bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset in_ready", bus.in_ready, 1'b0);
    chk("reset bundle", act, '0);
    #10 reset = 1'b1;
    step();
    chk("post-reset in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_insn = tbl[i].w;
      step();
      bus.in_valid = 1'b0;
      e = '{insn: tbl[i].w, rd: tbl[i].rd, rs: tbl[i].rs, rt: tbl[i].rt, shamt: tbl[i].sh, aluop: tbl[i].alu,
            imm: tbl[i].imm, is_rtype: tbl[i].rty, use_imm: tbl[i].ui, reg_we: tbl[i].we, illegal: tbl[i].ill,
            exc_code: tbl[i].exc, exc_reg: 5'd30};
      chk($sformatf("vec%0d valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d bundle", i), act, e);
      step();
      chk($sformatf("vec%0d drained", i), bus.out_valid, 1'b0);
    end
    bus.in_valid = 1'b1;
    bus.in_insn = 32'h00C22000;
    step();
    chk("b2b first", bus.out_insn, 32'h00C22000);
    bus.in_insn = 32'h01022004;
    step();
    chk("b2b second", bus.out_insn, 32'h01022004);
    chk("b2b second aluop", bus.out_aluop, 5'd1);
    bus.in_valid = 1'b0;
    step();
    chk("b2b drained", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = 32'h28400005;
    step();
    chk("bp ready after 1", bus.in_ready, 1'b1);
    chk("bp head after 1", bus.out_insn, 32'h28400005);
    bus.in_insn = 32'h00C22000;
    step();
    chk("bp ready after 2", bus.in_ready, 1'b0);
    chk("bp head after 2", bus.out_insn, 32'h28400005);
    bus.in_insn = 32'h01022004;
    step();
    chk("bp head held", act, model(32'h28400005));
    chk("bp ready held", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp drain second", bus.out_insn, 32'h00C22000);
    chk("bp drain valid", bus.out_valid, 1'b1);
    chk("bp drain ready", bus.in_ready, 1'b1);
    step();
    chk("bp empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn = 32'h28400005;
    step();
    bus.in_insn = 32'h00C22000;
    step();
    flush = 1'b1;
    bus.in_insn = 32'h01022004;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush valid", bus.out_valid, 1'b0);
    chk("flush ready", bus.in_ready, 1'b1);
    step();
    chk("flush dropped", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_insn = 32'h28400005;
    step();
    bus.in_valid = 1'b0;
    chk("areset pre valid", bus.out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("areset valid", bus.out_valid, 1'b0);
    chk("areset ready", bus.in_ready, 1'b0);
    chk("areset insn", bus.out_insn, 32'h0);
    #2 reset = 1'b1;
    step();
    chk("areset recover ready", bus.in_ready, 1'b1);
    chk("areset recover valid", bus.out_valid, 1'b0);
    q.delete();
    rdy_m = 1'b1;
    for (int n = 0; n < 800; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:27] = 5'd0;
        1: w[31:27] = 5'd5;
        2: begin w[31:27] = 5'd0; w[6:2] = 5'($urandom_range(0, 6)); end
        default: ;
      endcase
      bus.in_insn = w;
      bus.in_valid = $urandom_range(0, 2) != 0;
      bus.out_ready = $urandom_range(0, 1) != 0;
      flush = $urandom_range(0, 31) == 0;
      acc = bus.in_valid && rdy_m;
      pp = q.size() > 0 && bus.out_ready;
      step();
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(w);
      end
      rdy_m = q.size() < 2;
      chk("rnd valid", bus.out_valid, q.size() > 0);
      chk("rnd ready", bus.in_ready, rdy_m);
      if (q.size() > 0) chk("rnd head", act, model(q[0]));
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
